// File: rtl/sb_arbiter_pkg.sv
// Shared types for the scoreboard arbiter: entry layout, processor count and op encodings.
// Latency: none (types and constants only).
// Backpressure: n/a.
`ifndef PROC_COUNT
`define PROC_COUNT 4
`endif

package sb_arbiter_pkg;

    localparam int PROC_W = (`PROC_COUNT > 1) ? $clog2(`PROC_COUNT) : 1;
    localparam int CMD_W  = 8;

    localparam logic [1:0] SB_OP_READ  = 2'd0;
    localparam logic [1:0] SB_OP_WRITE = 2'd1;
    localparam logic [1:0] SB_OP_FLUSH = 2'd2;

    typedef struct packed {
        logic [CMD_W-1:0]  cmd_id;
        logic [PROC_W-1:0] proc_id;
    } entry_t;

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_RESP} state_t;

    // What the in-flight operation is; K_FVAL is a done-driven flush_val.
    typedef enum logic [1:0] {K_READ, K_WRITE, K_FLUSH, K_FVAL} kind_t;

    function automatic kind_t iss_kind(input logic [1:0] op);
        case (op)
            SB_OP_WRITE: return K_WRITE;
            SB_OP_FLUSH: return K_FLUSH;
            default:     return K_READ;
        endcase
    endfunction

endpackage

// File: rtl/sb_arbiter_rr.sv
// rr_picker: one-hot round-robin grant over pending done bits, searching from the slot after the last served.
// Latency: grant is combinational; the pointer moves on the cycle after i_ack.
// Backpressure: grant is only a proposal; the pointer advances solely when the owner acks the served slot.
module rr_picker #(
    parameter int NPROC = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rstn,
    input  logic [NPROC-1:0]         i_req,
    input  logic                     i_ack,
    input  logic [$clog2(NPROC)-1:0] i_ack_id,
    output logic [NPROC-1:0]         o_gnt,
    output logic [$clog2(NPROC)-1:0] o_gnt_id
);
    localparam int IDW = $clog2(NPROC);

    logic [IDW-1:0] ptr_q;
    logic [IDW-1:0] idx;
    logic           found;

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            ptr_q <= '0;
        end else if (i_ack) begin
            ptr_q <= i_ack_id;
        end
    end

    always_comb begin
        o_gnt    = '0;
        o_gnt_id = '0;
        found    = 1'b0;
        idx      = '0;
        for (int i = 1; i <= NPROC; i++) begin
            idx = IDW'((int'(ptr_q) + i) % NPROC);
            if (!found && i_req[idx]) begin
                found      = 1'b1;
                o_gnt[idx] = 1'b1;
                o_gnt_id   = idx;
            end
        end
    end

endmodule

// File: rtl/sb_arbiter.sv
// sb_arbiter: serialises issuer ops and per-processor done flushes onto one scoreboard port; watchdog under SB_ARB_TIMEOUT_EN.
// Latency: strobe 1 cycle after selection, o_iss_done 1 cycle after ack; a WRITE to a full table completes 1 cycle after selection.
// Backpressure: issuer holds i_iss_req until o_iss_done; done pulses park as pending bits; one op in flight at a time.
module sb_arbiter
    import sb_arbiter_pkg::*;
#(
    parameter int NPROC   = `PROC_COUNT,
    parameter int TIMEOUT = 64
) (
    input  logic                       i_clk,
    input  logic                       i_rstn,
    input  logic                       i_iss_req,
    input  logic [1:0]                 i_iss_op,
    input  entry_t                     i_iss_entry,
    output logic                       o_iss_done,
    output logic                       o_iss_exists,
    output logic [$clog2(NPROC)-1:0]   o_iss_id,
    input  logic [NPROC-1:0]           i_done,
    output entry_t                     o_sb_entry,
    output logic                       o_sb_write,
    output logic                       o_sb_read,
    output logic                       o_sb_flush,
    output logic                       o_sb_flush_val,
    input  logic                       i_sb_ack,
    input  logic                       i_sb_exists,
    input  logic [$clog2(NPROC)-1:0]   i_sb_id,
    output logic [$clog2(NPROC):0]     o_count,
    output logic                       o_timeout
);
    localparam int IDW = $clog2(NPROC);
    localparam int CW  = IDW + 1;

    state_t           state_q, state_d;
    kind_t            kind_q;
    entry_t           entry_q, fval_entry;
    logic             exists_q;
    logic [IDW-1:0]   id_q;
    logic [NPROC-1:0] pending_q, pend_clr, rr_gnt;
    logic [IDW-1:0]   rr_id;
    logic [CW-1:0]    count_q;
    logic             last_iss_q;
    logic             done_avail, iss_sel, done_sel, full_rej;
    logic             sb_acked, fval_acked, wait_expire;

    // When both sides want the port, whoever did not win last time goes next.
    assign done_avail = |rr_gnt;
    assign iss_sel    = i_iss_req && (!done_avail || !last_iss_q);
    assign done_sel   = done_avail && !iss_sel;
    assign full_rej   = (iss_kind(i_iss_op) == K_WRITE) && (count_q == CW'(NPROC));
    assign sb_acked   = (state_q == ST_WAIT) && i_sb_ack;
    assign fval_acked = sb_acked && (kind_q == K_FVAL);

    always_comb begin
        pend_clr = '0;
        if (fval_acked) pend_clr[entry_q.proc_id] = 1'b1;
    end

    always_comb begin
        fval_entry         = '0;
        fval_entry.proc_id = PROC_W'(rr_id);
    end

    rr_picker #(.NPROC(NPROC)) u_rr (
        .i_clk    (i_clk),
        .i_rstn   (i_rstn),
        .i_req    (pending_q),
        .i_ack    (fval_acked),
        .i_ack_id (IDW'(entry_q.proc_id)),
        .o_gnt    (rr_gnt),
        .o_gnt_id (rr_id)
    );

`ifdef SB_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] wait_cnt_q;
    logic          timeout_q;

    assign wait_expire = (state_q == ST_WAIT) && !i_sb_ack && (wait_cnt_q == TW'(TIMEOUT - 1));
    assign o_timeout   = timeout_q;

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            wait_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            wait_cnt_q <= (state_q == ST_WAIT && !i_sb_ack) ? wait_cnt_q + 1'b1 : '0;
            if (wait_expire) timeout_q <= 1'b1;
        end
    end
`else
    // TIMEOUT is referenced only to keep the parameter live; the expression is always 0.
    assign wait_expire = 1'b0 & (TIMEOUT < 0);
    assign o_timeout   = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (!i_rstn) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (iss_sel && full_rej)    state_d = ST_RESP;
                else if (iss_sel || done_sel) state_d = ST_ISSUE;
            end
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT:  if (i_sb_ack || wait_expire) state_d = ST_RESP;
            ST_RESP:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        o_sb_write     = 1'b0;
        o_sb_read      = 1'b0;
        o_sb_flush     = 1'b0;
        o_sb_flush_val = 1'b0;
        if (state_q == ST_ISSUE) begin
            o_sb_write     = (kind_q == K_WRITE);
            o_sb_read      = (kind_q == K_READ);
            o_sb_flush     = (kind_q == K_FLUSH);
            o_sb_flush_val = (kind_q == K_FVAL);
        end
        o_iss_done   = (state_q == ST_RESP) && (kind_q != K_FVAL);
        o_iss_exists = o_iss_done && exists_q;
        o_iss_id     = o_iss_done ? id_q : '0;
    end

    assign o_sb_entry = entry_q;
    assign o_count    = count_q;

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            kind_q     <= K_READ;
            entry_q    <= '0;
            exists_q   <= 1'b0;
            id_q       <= '0;
            pending_q  <= '0;
            count_q    <= '0;
            last_iss_q <= 1'b0;
        end else begin
            pending_q <= (pending_q & ~pend_clr) | i_done;
            if (state_q == ST_IDLE && (iss_sel || done_sel)) begin
                last_iss_q <= iss_sel;
                kind_q     <= iss_sel ? iss_kind(i_iss_op) : K_FVAL;
                entry_q    <= iss_sel ? i_iss_entry : fval_entry;
                exists_q   <= 1'b0;
                id_q       <= '0;
            end
            if (sb_acked) begin
                exists_q <= (kind_q == K_WRITE) || i_sb_exists;
                id_q     <= i_sb_id;
                if (kind_q == K_WRITE) begin
                    if (count_q != CW'(NPROC)) count_q <= count_q + 1'b1;
                end else if (kind_q != K_READ && i_sb_exists && count_q != '0) begin
                    count_q <= count_q - 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_sb_arbiter.sv
// Directed bench for sb_arbiter (NPROC=4, TIMEOUT=8); the watchdog scenario adapts to SB_ARB_TIMEOUT_EN.
module tb_sb_arbiter;
    import sb_arbiter_pkg::*;

    localparam int NP = 4;
    localparam int TO = 8;

    logic       i_clk = 1'b0;
    logic       i_rstn;
    logic       i_iss_req;
    logic [1:0] i_iss_op;
    entry_t     i_iss_entry;
    logic       o_iss_done, o_iss_exists;
    logic [1:0] o_iss_id;
    logic [3:0] i_done;
    entry_t     o_sb_entry;
    logic       o_sb_write, o_sb_read, o_sb_flush, o_sb_flush_val;
    logic       i_sb_ack, i_sb_exists;
    logic [1:0] i_sb_id;
    logic [2:0] o_count;
    logic       o_timeout;

    int errors = 0;
    int checks = 0;

    always #5 i_clk = ~i_clk;

    sb_arbiter #(.NPROC(NP), .TIMEOUT(TO)) dut (
        .i_clk(i_clk), .i_rstn(i_rstn),
        .i_iss_req(i_iss_req), .i_iss_op(i_iss_op), .i_iss_entry(i_iss_entry),
        .o_iss_done(o_iss_done), .o_iss_exists(o_iss_exists), .o_iss_id(o_iss_id),
        .i_done(i_done),
        .o_sb_entry(o_sb_entry), .o_sb_write(o_sb_write), .o_sb_read(o_sb_read),
        .o_sb_flush(o_sb_flush), .o_sb_flush_val(o_sb_flush_val),
        .i_sb_ack(i_sb_ack), .i_sb_exists(i_sb_exists), .i_sb_id(i_sb_id),
        .o_count(o_count), .o_timeout(o_timeout)
    );

    function automatic entry_t mk(input int cmd, input int proc);
        entry_t e;
        e.cmd_id  = CMD_W'(cmd);
        e.proc_id = PROC_W'(proc);
        return e;
    endfunction

    // Drives one issuer op and acts as scoreboard (ack ack_dly cycles after the strobe); bounded at 60 cycles.
    task automatic run_iss(input logic [1:0] op, input entry_t e, input int ack_dly,
                           input logic ex, input logic [1:0] id,
                           output logic done, output logic dex, output logic [1:0] did,
                           output int wr_n, output int rd_n, output int fl_n, output int cyc);
        int since;
        done = 1'b0; dex = 1'b0; did = 2'd0; wr_n = 0; rd_n = 0; fl_n = 0; cyc = 0; since = -1;
        @(negedge i_clk);
        i_iss_req = 1'b1; i_iss_op = op; i_iss_entry = e;
        for (int c = 1; c <= 60 && !done; c++) begin
            @(negedge i_clk);
            i_sb_ack = 1'b0;
            if (o_sb_write) wr_n++;
            if (o_sb_read)  rd_n++;
            if (o_sb_flush) fl_n++;
            if (o_sb_write || o_sb_read || o_sb_flush) since = 0;
            else if (since >= 0) since++;
            if (o_iss_done) begin
                done = 1'b1; dex = o_iss_exists; did = o_iss_id; cyc = c; i_iss_req = 1'b0;
            end else if (since == ack_dly) begin
                i_sb_ack = 1'b1; i_sb_exists = ex; i_sb_id = id;
            end
        end
        i_iss_req = 1'b0;
        i_sb_ack  = 1'b0;
    endtask

    task automatic test_reset();
        i_rstn = 1'b0;
        repeat (3) @(negedge i_clk);
        checks++; if (o_count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", o_count); end
        checks++; if (o_timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b want 0", o_timeout); end
        checks++; if ({o_iss_done, o_iss_exists, o_iss_id} !== 4'b0) begin errors++; $display("FAIL reset_iss: got %b want 0000", {o_iss_done, o_iss_exists, o_iss_id}); end
        checks++; if ({o_sb_write, o_sb_read, o_sb_flush, o_sb_flush_val} !== 4'b0) begin errors++; $display("FAIL reset_strobes: got %b want 0000", {o_sb_write, o_sb_read, o_sb_flush, o_sb_flush_val}); end
        checks++; if (o_sb_entry !== entry_t'(0)) begin errors++; $display("FAIL reset_entry: got %h want 0", o_sb_entry); end
        i_rstn = 1'b1;
    endtask

    task automatic test_write();
        logic d, ex; logic [1:0] id; int wr, rd, fl, cyc;
        run_iss(SB_OP_WRITE, mk(5, 2), 3, 1'b0, 2'd0, d, ex, id, wr, rd, fl, cyc);
        checks++; if (d !== 1'b1) begin errors++; $display("FAIL write_done: got %b want 1", d); end
        checks++; if (ex !== 1'b1) begin errors++; $display("FAIL write_exists: got %b want 1", ex); end
        checks++; if (wr != 1 || rd != 0 || fl != 0) begin errors++; $display("FAIL write_strobe: got wr=%0d rd=%0d fl=%0d want 1/0/0", wr, rd, fl); end
        checks++; if (cyc != 5) begin errors++; $display("FAIL write_latency: got %0d want 5", cyc); end
        checks++; if (o_count !== 3'd1) begin errors++; $display("FAIL write_count: got %0d want 1", o_count); end
        checks++; if (o_sb_entry !== mk(5, 2)) begin errors++; $display("FAIL write_entry: got %h want %h", o_sb_entry, mk(5, 2)); end
    endtask

    task automatic test_read();
        logic d, ex; logic [1:0] id; int wr, rd, fl, cyc;
        run_iss(SB_OP_READ, mk(5, 0), 1, 1'b1, 2'd2, d, ex, id, wr, rd, fl, cyc);
        checks++; if (d !== 1'b1 || ex !== 1'b1) begin errors++; $display("FAIL read_hit: got done=%b exists=%b want 1/1", d, ex); end
        checks++; if (id !== 2'd2) begin errors++; $display("FAIL read_hit_id: got %0d want 2", id); end
        checks++; if (rd != 1 || wr != 0 || cyc != 3) begin errors++; $display("FAIL read_hit_strobe: got rd=%0d wr=%0d cyc=%0d want 1/0/3", rd, wr, cyc); end
        run_iss(2'd3, mk(9, 0), 1, 1'b0, 2'd3, d, ex, id, wr, rd, fl, cyc);
        checks++; if (d !== 1'b1 || ex !== 1'b0) begin errors++; $display("FAIL read_miss: got done=%b exists=%b want 1/0", d, ex); end
        checks++; if (rd != 1) begin errors++; $display("FAIL read_op3_as_read: got rd=%0d want 1", rd); end
        checks++; if (o_count !== 3'd1) begin errors++; $display("FAIL read_count: got %0d want 1", o_count); end
    endtask

    task automatic test_full();
        logic d, ex; logic [1:0] id; int wr, rd, fl, cyc;
        run_iss(SB_OP_WRITE, mk(6, 0), 1, 1'b0, 2'd0, d, ex, id, wr, rd, fl, cyc);
        run_iss(SB_OP_WRITE, mk(7, 1), 2, 1'b0, 2'd0, d, ex, id, wr, rd, fl, cyc);
        run_iss(SB_OP_WRITE, mk(8, 3), 1, 1'b0, 2'd0, d, ex, id, wr, rd, fl, cyc);
        checks++; if (o_count !== 3'd4) begin errors++; $display("FAIL full_count: got %0d want 4", o_count); end
        run_iss(SB_OP_WRITE, mk(9, 0), 1, 1'b1, 2'd0, d, ex, id, wr, rd, fl, cyc);
        checks++; if (d !== 1'b1 || ex !== 1'b0) begin errors++; $display("FAIL full_reject: got done=%b exists=%b want 1/0", d, ex); end
        checks++; if (wr != 0) begin errors++; $display("FAIL full_no_write: got %0d write strobes want 0", wr); end
        checks++; if (cyc != 1) begin errors++; $display("FAIL full_latency: got %0d want 1", cyc); end
        checks++; if (o_count !== 3'd4) begin errors++; $display("FAIL full_count_kept: got %0d want 4", o_count); end
    endtask

    task automatic test_flush_val();
        int n, since, dones;
        logic [1:0] order [2];
        logic [2:0] cnt_at [2];
        n = 0; since = -1; dones = 0;
        order[0] = 2'd0; order[1] = 2'd0; cnt_at[0] = 3'd0; cnt_at[1] = 3'd0;
        @(negedge i_clk); i_done = 4'b1010;
        @(negedge i_clk); i_done = 4'b0000;
        for (int c = 0; c < 30; c++) begin
            @(negedge i_clk);
            i_sb_ack = 1'b0;
            if (o_iss_done) dones++;
            if (o_sb_flush_val) begin
                if (n < 2) begin order[n] = o_sb_entry.proc_id; cnt_at[n] = o_count; end
                n++; since = 0;
            end else if (since >= 0) since++;
            if (since == 1) begin i_sb_ack = 1'b1; i_sb_exists = 1'b1; i_sb_id = 2'd0; since = -1; end
        end
        checks++; if (n != 2) begin errors++; $display("FAIL fval_count: got %0d flush_val want 2", n); end
        checks++; if (order[0] !== 2'd1 || order[1] !== 2'd3) begin errors++; $display("FAIL fval_order: got %0d,%0d want 1,3", order[0], order[1]); end
        checks++; if (cnt_at[0] !== 3'd4 || cnt_at[1] !== 3'd3) begin errors++; $display("FAIL fval_dec_step: got %0d,%0d want 4,3", cnt_at[0], cnt_at[1]); end
        checks++; if (o_count !== 3'd2) begin errors++; $display("FAIL fval_final_count: got %0d want 2", o_count); end
        checks++; if (dones != 0) begin errors++; $display("FAIL fval_no_iss_done: got %0d want 0", dones); end
    endtask

    task automatic test_alternate();
        int n, since, dones;
        logic seq [6];
        n = 0; since = -1; dones = 0;
        for (int i = 0; i < 6; i++) seq[i] = 1'b0;
        i_iss_req = 1'b1; i_iss_op = SB_OP_READ; i_iss_entry = mk(3, 0); i_done = 4'b0001;
        for (int c = 0; c < 46; c++) begin
            @(negedge i_clk);
            i_sb_ack = 1'b0;
            if (c == 30) begin i_iss_req = 1'b0; i_done = 4'b0000; end
            if (o_iss_done) dones++;
            if (o_sb_read || o_sb_flush_val) begin
                if (n < 6) seq[n] = o_sb_flush_val;
                n++; since = 0;
            end else if (since >= 0) since++;
            if (since == 1) begin i_sb_ack = 1'b1; i_sb_exists = 1'b0; i_sb_id = 2'd0; since = -1; end
        end
        checks++; if (n < 6) begin errors++; $display("FAIL alt_services: got %0d want >=6", n); end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (seq[i] !== i[0]) begin errors++; $display("FAIL alt_seq[%0d]: got %0d want %0d (0=issuer 1=flush_val)", i, seq[i], i[0]); end
        end
        checks++; if (dones < 3) begin errors++; $display("FAIL alt_iss_done: got %0d want >=3", dones); end
        checks++; if (o_count !== 3'd2) begin errors++; $display("FAIL alt_count: got %0d want 2", o_count); end
    endtask

    task automatic test_timeout_reset();
        int to_c, done_c, dones;
        logic dex;
        to_c = 0; done_c = 0; dex = 1'b1; dones = 0;
        @(negedge i_clk);
        i_iss_req = 1'b1; i_iss_op = SB_OP_READ; i_iss_entry = mk(11, 1);
        for (int c = 1; c <= TO + 4; c++) begin
            @(negedge i_clk);
            if (o_timeout && to_c == 0) to_c = c;
            if (o_iss_done && done_c == 0) begin done_c = c; dex = o_iss_exists; i_iss_req = 1'b0; end
        end
`ifdef SB_ARB_TIMEOUT_EN
        checks++; if (to_c != TO + 2) begin errors++; $display("FAIL to_flag_cycle: got %0d want %0d", to_c, TO + 2); end
        checks++; if (done_c != TO + 2 || dex !== 1'b0) begin errors++; $display("FAIL to_done: got cyc=%0d exists=%b want %0d/0", done_c, dex, TO + 2); end
        i_iss_req = 1'b1;
        repeat (3) @(negedge i_clk);
        checks++; if (o_timeout !== 1'b1) begin errors++; $display("FAIL to_sticky: got %b want 1", o_timeout); end
`else
        checks++; if (to_c != 0) begin errors++; $display("FAIL to_tied_off: got first set at %0d want never", to_c); end
        checks++; if (done_c != 0) begin errors++; $display("FAIL wait_no_done: got done at %0d want none", done_c); end
`endif
        checks++; if ({o_sb_write, o_sb_read, o_sb_flush, o_sb_flush_val} !== 4'b0 || o_count !== 3'd2) begin
            errors++; $display("FAIL wait_state: got strobes=%b count=%0d want 0000/2", {o_sb_write, o_sb_read, o_sb_flush, o_sb_flush_val}, o_count); end
        i_rstn = 1'b0; i_iss_req = 1'b0;
        @(negedge i_clk);
        checks++; if (o_count !== 3'd0 || o_timeout !== 1'b0) begin errors++; $display("FAIL midop_reset: got count=%0d timeout=%b want 0/0", o_count, o_timeout); end
        checks++; if (o_iss_done !== 1'b0 || o_sb_entry !== entry_t'(0)) begin errors++; $display("FAIL midop_outputs: got done=%b entry=%h want 0/0", o_iss_done, o_sb_entry); end
        i_rstn = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge i_clk);
            if (o_iss_done || o_sb_write || o_sb_read || o_sb_flush || o_sb_flush_val) dones++;
        end
        checks++; if (dones != 0) begin errors++; $display("FAIL midop_abandon: got %0d activity cycles want 0", dones); end
    endtask

    initial begin
        i_rstn = 1'b0; i_iss_req = 1'b0; i_iss_op = 2'd0; i_iss_entry = '0;
        i_done = 4'b0; i_sb_ack = 1'b0; i_sb_exists = 1'b0; i_sb_id = 2'd0;
        test_reset();
        test_write();
        test_read();
        test_full();
        test_flush_val();
        test_alternate();
        test_timeout_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at 200000, want finished");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/sb_arbiter.md
SB_ARBITER -- requirements
Module: sb_arbiter

Interface
REQ-001 SHALL have parameter NPROC, default `PROC_COUNT, meaning the number of processors, scoreboard slots and done lines.
REQ-002 SHALL have parameter TIMEOUT, default 64, meaning the maximum cycles to wait for scoreboard ack (used only under SB_ARB_TIMEOUT_EN).
REQ-003 SHALL have one clock and a synchronous, active-low reset: i_clk, i_rstn.
REQ-004 Ports (name  direction  width  meaning):
- i_clk  in  1  clock
- i_rstn  in  1  synchronous active-low reset
- i_iss_req  in  1  issuer request, held until o_iss_done
- i_iss_op  in  2  0=READ, 1=WRITE, 2=FLUSH (3 is treated as READ)
- i_iss_entry  in  entry_t  key/value for the issuer op
- o_iss_done  out  1  one-cycle completion pulse
- o_iss_exists  out  1  key found / write accepted; valid with done
- o_iss_id  out  $clog2(NPROC)  proc id read back; valid with done
- i_done  in  NPROC  per-processor completion pulses
- o_sb_entry, o_sb_write, o_sb_read, o_sb_flush, o_sb_flush_val  out  entry_t/1/1/1/1  scoreboard drive
- i_sb_ack, i_sb_exists, i_sb_id  in  1/1/$clog2(NPROC)  scoreboard response
- o_count  out  $clog2(NPROC)+1  occupied slot count
- o_timeout  out  1  sticky watchdog flag

Function
REQ-005 FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE->ISSUE when any request is selected.
- ISSUE->WAIT after exactly 1 cycle.
- WAIT->RESP on i_sb_ack.
- RESP->IDLE after 1 cycle.
REQ-006 In ISSUE, exactly one o_sb_* strobe is high for exactly one cycle; all strobes are 0 in every other state.
REQ-007 o_sb_entry is registered when the request is selected and held stable from ISSUE through RESP.
REQ-008 Each i_done[k] pulse sets pending[k].
- If set and clear hit the same bit in the same cycle, set wins.
- A pulse on an already-pending bit merges into the pending flush.
REQ-009 A pending done is served as a flush_val with o_sb_entry.proc_id=k, chosen round-robin from the bit after the last one served; pending[k] clears on its ack.
REQ-010 Arbitration in IDLE: when both an issuer request and a pending done exist, they alternate. Otherwise the sole requester wins.
REQ-011 An issuer WRITE with o_count==NPROC is not forwarded: o_iss_done and o_iss_exists=0 follow one cycle later, and the count is unchanged.
REQ-012 o_count updates on ack:
- +1 on WRITE.
- -1 on FLUSH or flush_val acked with i_sb_exists=1.
- Saturates at 0 and NPROC.
REQ-013 For an issuer op, in RESP: o_iss_done=1, o_iss_exists is i_sb_exists as latched at ack (1 for WRITE), o_iss_id is i_sb_id as latched at ack.
REQ-014 A flush_val completion never pulses o_iss_done.
REQ-015 Minimum issue-to-issue spacing is 4 cycles, which guarantees the scoreboard has returned to its idle state.

Reset
REQ-016 When i_rstn=0 at a clock edge, the block SHALL enter IDLE and clear pending, the round-robin pointer, o_count and o_timeout to 0; all outputs go to 0.
REQ-017 A reset mid-operation SHALL abandon the operation with no o_iss_done.

Configuration
REQ-018 With SB_ARB_TIMEOUT_EN defined:
- A WAIT lasting TIMEOUT cycles forces RESP with exists=0 and sets o_timeout, which stays set until reset.
- A timed-out issuer op pulses o_iss_done.
- A timed-out flush_val leaves pending set.
REQ-019 Without SB_ARB_TIMEOUT_EN, WAIT waits for i_sb_ack indefinitely, o_timeout is tied to 0, and no counter is instantiated.

Structure
REQ-020 entry_t, PROC_COUNT and the op encodings (SB_OP_READ/WRITE/FLUSH) SHALL live in the shared package/defines.
REQ-021 The round-robin picker SHALL be a sub-module rr_picker (NPROC-wide request vector in, one-hot grant out, pointer update on ack).

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- Issuer WRITE {cmd_id=5,proc_id=2}, ack after 3 cycles -> o_sb_write high 1 cycle, o_iss_done with exists=1, o_count=1.
- Issuer READ cmd_id=5 with sb returning exists=1, id=2 -> o_iss_exists=1, o_iss_id=2; READ cmd_id=9 with exists=0 -> o_iss_exists=0.
- i_done=4'b1010 in one cycle -> flush_val issued for proc 1 then proc 3; o_count decrements per ack with exists=1; no o_iss_done.
- o_count==NPROC plus issuer WRITE -> no o_sb_write; o_iss_done with exists=0 after 1 cycle.
- Issuer request and i_done[0] asserted together, repeatedly -> services alternate; neither starves.
- SB_ARB_TIMEOUT_EN, TIMEOUT=8, no ack -> o_timeout set at cycle 8 of WAIT; a reset in WAIT -> IDLE, o_count=0, no done.
